// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, parallel load, shift and rotate with a
// start/busy/done handshake. The default build moves one bit position per
// clock. Defining USR_BARREL_EN replaces the iterative engine with a
// single-edge barrel shifter producing the same final data_out and ser_out.
module universal_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;

    logic [WIDTH-1:0] q, q_next;
    logic             so, so_next;
    logic             done_q, done_next;
    logic [WIDTH:0]   step_res;
    logic             is_shift;
    logic [AW-1:0]    n_eff;

    // One single-bit step; returns {bit shifted out, new register value}.
    function automatic logic [WIDTH:0] step_once(input logic [WIDTH-1:0] cur,
                                                 input logic [2:0]       sop,
                                                 input logic             fill);
        logic [WIDTH:0] r;
        case (sop)
            OP_SHL:  r = {cur[WIDTH-1], cur[WIDTH-2:0], fill};
            OP_ROL:  r = {cur[WIDTH-1], cur[WIDTH-2:0], cur[WIDTH-1]};
            OP_SHR:  r = {cur[0], fill, cur[WIDTH-1:1]};
            OP_SRA:  r = {cur[0], cur[WIDTH-1], cur[WIDTH-1:1]};
            OP_ROR:  r = {cur[0], cur[0], cur[WIDTH-1:1]};
            default: r = {1'b0, cur};
        endcase
        return r;
    endfunction

    assign is_shift = (op >= OP_SHL) && (op <= OP_ROR);
    assign n_eff    = (amount > AW'(WIDTH)) ? AW'(WIDTH) : amount;

    assign data_out = q;
    assign ser_out  = so;
    assign done     = done_q;

`ifdef USR_BARREL_EN

    logic [WIDTH-1:0] barrel_q;
    logic             barrel_so;

    assign busy = 1'b0;

    // Chain N_eff single steps combinationally so every command completes at its accept edge.
    always_comb begin
        q_next    = q;
        so_next   = so;
        done_next = 1'b0;
        barrel_q  = q;
        barrel_so = so;
        step_res  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(n_eff)) begin
                step_res  = step_once(barrel_q, op, ser_in);
                barrel_q  = step_res[WIDTH-1:0];
                barrel_so = step_res[WIDTH];
            end
        end
        if (start) begin
            done_next = 1'b1;
            if (op == OP_LOAD) begin
                q_next = data_in;
            end else if (is_shift) begin
                q_next  = barrel_q;
                so_next = barrel_so;
            end
        end
    end

    // Register contents, last shifted-out bit and the completion pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q      <= '0;
            so     <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q      <= q_next;
            so     <= so_next;
            done_q <= done_next;
        end
    end

`else

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_next;
    logic [AW-1:0] cnt, cnt_next;
    logic [2:0]    op_l, op_next;
    logic          fill_l, fill_next;

    assign busy = (state == SHIFT);

    // Accept commands in IDLE; in SHIFT apply one latched step per clock until the count runs out.
    always_comb begin
        state_next = state;
        q_next     = q;
        so_next    = so;
        done_next  = 1'b0;
        cnt_next   = cnt;
        op_next    = op_l;
        fill_next  = fill_l;
        step_res   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_LOAD) begin
                        q_next    = data_in;
                        done_next = 1'b1;
                    end else if (is_shift && (n_eff != '0)) begin
                        state_next = SHIFT;
                        cnt_next   = n_eff;
                        op_next    = op;
                        fill_next  = ser_in;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            SHIFT: begin
                step_res = step_once(q, op_l, fill_l);
                q_next   = step_res[WIDTH-1:0];
                so_next  = step_res[WIDTH];
                cnt_next = cnt - 1'b1;
                if (cnt == AW'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus datapath and latched command fields; reset clears everything at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            q      <= '0;
            so     <= 1'b0;
            done_q <= 1'b0;
            cnt    <= '0;
            op_l   <= '0;
            fill_l <= 1'b0;
        end else begin
            state  <= state_next;
            q      <= q_next;
            so     <= so_next;
            done_q <= done_next;
            cnt    <= cnt_next;
            op_l   <= op_next;
            fill_l <= fill_next;
        end
    end

`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// Randomised self-checking bench for universal_shift_reg (WIDTH=8) against an
// arithmetic reference model of the shift/rotate rules.
module tb_universal_shift_reg;

    localparam int W = 8;
`ifdef USR_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic [3:0] amount = 4'd0;
    logic [7:0] data_in = 8'd0;
    logic       ser_in = 1'b0;
    logic [7:0] data_out;
    logic       ser_out;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_q = 8'd0;
    logic       m_so = 1'b0;

    universal_shift_reg #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .amount(amount),
        .data_in(data_in), .ser_in(ser_in), .data_out(data_out),
        .ser_out(ser_out), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // Reference model: result of a whole command computed with plain arithmetic.
    task automatic model_apply(input logic [2:0] o, input logic [3:0] a,
                               input logic [7:0] d, input logic s);
        int n, q, sq, r;
        n = (a > 4'd8) ? 8 : int'(a);
        q = int'(m_q);
        if (o == 3'd1) begin
            m_q = d;
        end else if (o >= 3'd2 && o <= 3'd6 && n > 0) begin
            case (o)
                3'd2: begin
                    r    = ((q << n) | (s ? ((1 << n) - 1) : 0)) & 255;
                    m_so = 1'((q >> (8 - n)) & 1);
                end
                3'd3: begin
                    r    = (q >> n) | (s ? (255 ^ (255 >> n)) : 0);
                    m_so = 1'((q >> (n - 1)) & 1);
                end
                3'd4: begin
                    sq   = (q >= 128) ? q - 256 : q;
                    r    = (sq >>> n) & 255;
                    m_so = 1'((q >> (n - 1)) & 1);
                end
                3'd5: begin
                    r    = ((q << n) | (q >> (8 - n))) & 255;
                    m_so = 1'(r & 1);
                end
                default: begin
                    r    = ((q >> n) | (q << (8 - n))) & 255;
                    m_so = 1'((r >> 7) & 1);
                end
            endcase
            m_q = 8'(r);
        end
    endtask

    function automatic int exp_busy(input logic [2:0] o, input logic [3:0] a);
        if (BARREL || o < 3'd2 || o > 3'd6) return 0;
        return (a > 4'd8) ? 8 : int'(a);
    endfunction

    // Drive one command for one edge, then follow busy until done (bounded).
    task automatic run_cmd(input logic [2:0] c_op, input logic [3:0] c_amt,
                           input logic [7:0] c_data, input logic c_ser,
                           output int busy_cyc, output bit seen_done, output bit overlap);
        op = c_op; amount = c_amt; data_in = c_data; ser_in = c_ser; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        busy_cyc = 0; seen_done = 1'b0; overlap = 1'b0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            if (done) begin
                seen_done = 1'b1;
                if (busy) overlap = 1'b1;
            end else begin
                if (busy) busy_cyc++;
                @(posedge CLK); #1;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #23;
        vectors++;
        if (data_out !== 8'h00 || ser_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got data=%h ser=%b busy=%b done=%b, want 00 0 0 0",
                     data_out, ser_out, busy, done);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_load();
        int bc; bit sd, ov;
        run_cmd(3'd1, 4'd0, 8'hA5, 1'b0, bc, sd, ov);
        model_apply(3'd1, 4'd0, 8'hA5, 1'b0);
        vectors++;
        if (!sd || bc != 0 || ov || data_out !== 8'hA5 || ser_out !== m_so) begin
            miscompares++;
            $display("[TB] FAIL load_a5: got data=%h done=%b busy_cyc=%0d ser=%b, want a5 1 0 %b",
                     data_out, sd, bc, ser_out, m_so);
        end
        @(posedge CLK); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_done_width: got done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_rotate();
        int bc; bit sd, ov;
        run_cmd(3'd5, 4'd3, 8'h00, 1'b0, bc, sd, ov);
        model_apply(3'd5, 4'd3, 8'h00, 1'b0);
        vectors++;
        if (!sd || ov || bc != exp_busy(3'd5, 4'd3) || data_out !== 8'h2D || ser_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rol3: got data=%h ser=%b busy_cyc=%0d done=%b, want 2d 1 %0d 1",
                     data_out, ser_out, bc, sd, exp_busy(3'd5, 4'd3));
        end
    endtask

    task automatic test_clamp();
        int bc; bit sd, ov;
        run_cmd(3'd1, 4'd0, 8'h90, 1'b0, bc, sd, ov);
        model_apply(3'd1, 4'd0, 8'h90, 1'b0);
        run_cmd(3'd4, 4'd9, 8'h00, 1'b0, bc, sd, ov);
        model_apply(3'd4, 4'd9, 8'h00, 1'b0);
        vectors++;
        if (!sd || ov || bc != exp_busy(3'd4, 4'd9) || data_out !== 8'hFF || ser_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sra_clamp: got data=%h ser=%b busy_cyc=%0d, want ff 1 %0d",
                     data_out, ser_out, bc, exp_busy(3'd4, 4'd9));
        end
    endtask

    task automatic test_ignore_start();
        int bc, dones; bit sd, ov;
        run_cmd(3'd1, 4'd0, 8'h01, 1'b0, bc, sd, ov);
        model_apply(3'd1, 4'd0, 8'h01, 1'b0);
        op = 3'd2; amount = 4'd2; data_in = 8'h00; ser_in = 1'b1; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        dones = int'(done);
`ifndef USR_BARREL_EN
        ser_in = 1'b0; op = 3'd1; data_in = 8'hEE; start = 1'b1;
`endif
        @(posedge CLK); #1;
        start = 1'b0;
        dones += int'(done);
        repeat (4) begin
            @(posedge CLK); #1;
            dones += int'(done);
        end
        model_apply(3'd2, 4'd2, 8'h00, 1'b1);
        vectors++;
        if (data_out !== 8'h07 || ser_out !== m_so || dones != 1) begin
            miscompares++;
            $display("[TB] FAIL shl_ignore_start: got data=%h ser=%b dones=%0d, want 07 %b 1",
                     data_out, ser_out, dones, m_so);
        end
    endtask

    task automatic test_zero_amount();
        int bc; bit sd, ov;
        logic prev_so;
        run_cmd(3'd1, 4'd0, 8'h3C, 1'b0, bc, sd, ov);
        model_apply(3'd1, 4'd0, 8'h3C, 1'b0);
        prev_so = m_so;
        run_cmd(3'd6, 4'd0, 8'h00, 1'b1, bc, sd, ov);
        model_apply(3'd6, 4'd0, 8'h00, 1'b1);
        vectors++;
        if (!sd || bc != 0 || data_out !== 8'h3C || ser_out !== prev_so) begin
            miscompares++;
            $display("[TB] FAIL ror_zero: got data=%h ser=%b busy_cyc=%0d done=%b, want 3c %b 0 1",
                     data_out, ser_out, bc, sd, prev_so);
        end
    endtask

    task automatic test_async_reset();
        int bc; bit sd, ov;
        run_cmd(3'd1, 4'd0, 8'hFF, 1'b0, bc, sd, ov);
        op = 3'd3; amount = 4'd8; ser_in = 1'b0; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        m_q = 8'h00; m_so = 1'b0;
        vectors++;
        if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got data=%h busy=%b done=%b ser=%b, want 00 0 0 0",
                     data_out, busy, done, ser_out);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        run_cmd(3'd1, 4'd0, 8'h12, 1'b0, bc, sd, ov);
        model_apply(3'd1, 4'd0, 8'h12, 1'b0);
        vectors++;
        if (!sd || data_out !== 8'h12 || ser_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_after_reset: got data=%h ser=%b done=%b, want 12 0 1",
                     data_out, ser_out, sd);
        end
    endtask

    task automatic test_back_to_back();
        int bc; bit sd, ov;
        run_cmd(3'd1, 4'd0, 8'hC3, 1'b0, bc, sd, ov);
        model_apply(3'd1, 4'd0, 8'hC3, 1'b0);
        run_cmd(3'd2, 4'd4, 8'h00, 1'b1, bc, sd, ov);
        model_apply(3'd2, 4'd4, 8'h00, 1'b1);
        vectors++;
        if (!sd || ov || bc != exp_busy(3'd2, 4'd4) || data_out !== m_q || ser_out !== m_so) begin
            miscompares++;
            $display("[TB] FAIL b2b_shl: got data=%h ser=%b busy_cyc=%0d, want %h %b %0d",
                     data_out, ser_out, bc, m_q, m_so, exp_busy(3'd2, 4'd4));
        end
        run_cmd(3'd3, 4'd3, 8'h00, 1'b1, bc, sd, ov);
        model_apply(3'd3, 4'd3, 8'h00, 1'b1);
        vectors++;
        if (!sd || ov || bc != exp_busy(3'd3, 4'd3) || data_out !== m_q || ser_out !== m_so) begin
            miscompares++;
            $display("[TB] FAIL b2b_shr: got data=%h ser=%b busy_cyc=%0d, want %h %b %0d",
                     data_out, ser_out, bc, m_q, m_so, exp_busy(3'd3, 4'd3));
        end
    endtask

    task automatic test_random();
        int bc; bit sd, ov;
        logic [2:0] r_op;
        logic [3:0] r_amt;
        logic [7:0] r_data;
        logic       r_ser;
        for (int i = 0; i < 60; i++) begin
            r_op   = 3'($urandom_range(0, 7));
            r_amt  = 4'($urandom_range(0, 15));
            r_data = 8'($urandom_range(0, 255));
            r_ser  = 1'($urandom_range(0, 1));
            if (i % 6 == 0) r_op = 3'd1;
            run_cmd(r_op, r_amt, r_data, r_ser, bc, sd, ov);
            model_apply(r_op, r_amt, r_data, r_ser);
            vectors++;
            if (!sd || ov || bc != exp_busy(r_op, r_amt) || data_out !== m_q || ser_out !== m_so) begin
                miscompares++;
                $display("[TB] FAIL random[%0d] op=%0d amt=%0d: got data=%h ser=%b busy_cyc=%0d done=%b overlap=%b, want %h %b %0d 1 0",
                         i, r_op, r_amt, data_out, ser_out, bc, sd, ov, m_q, m_so, exp_busy(r_op, r_amt));
            end
        end
    endtask

    // Run every scenario in order and report the totals.
    initial begin
        test_reset();
        test_load();
        test_rotate();
        test_clamp();
        test_ignore_start();
        test_zero_amount();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
